runway_occupancy_tracker: RTL

Receiving end of the runway-grant interface driven by `runway_picker`. The tracker consumes each one-cycle grant strobe (`en` plus the 4-bit `signal` word) and marks the granted runway occupied. It times the occupancy and a post-use clearing interval, and reports per-runway busy flags `A`/`B` back to the picker. Grants that cannot be honoured are flagged as conflicts.

---
 rtl/atc_pkg.sv | 21 ++
 rtl/runway_slot.sv | 71 +++++++
 rtl/runway_occupancy_tracker.sv | 78 +++++++
 3 files changed

// File: rtl/atc_pkg.sv
// Definitions shared by runway_picker and runway_occupancy_tracker:
// the runway state encoding, grant-word bit positions and a sizing helper.
package atc_pkg;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        OCCUPIED = 2'd1,
        CLEARING = 2'd2
    } runway_state_t;

    // Bit positions inside the 4-bit grant word
    localparam int unsigned SIG_A       = 0;
    localparam int unsigned SIG_B       = 1;
    localparam int unsigned SIG_DIR_LSB = 2;
    localparam int unsigned SIG_DIR_MSB = 3;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/runway_slot.sv
// One runway: FREE -> OCCUPIED -> CLEARING -> FREE, with an occupancy/clearing
// timer and the direction latched at the last accepted grant.
module runway_slot
    import atc_pkg::*;
#(
    parameter int unsigned OCC_CYCLES   = 8,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned TW           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grant,
    input  logic [1:0] dir,
    input  logic       vacate,
    output logic       busy,
    output logic [1:0] dir_q,
    output logic       reject
);

    localparam logic [TW-1:0] OCC_LOAD = TW'(OCC_CYCLES - 1);
    localparam logic [TW-1:0] CLR_LOAD = TW'(CLEAR_CYCLES - 1);

    runway_state_t state;
    logic [TW-1:0] timer;

    // Acceptance is judged on the state held before the edge
    assign reject = grant && (state != FREE);

    // Runway FSM, timer, direction latch and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FREE;
            timer <= '0;
            dir_q <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (grant) begin
                        state <= OCCUPIED;
                        timer <= OCC_LOAD;
                        dir_q <= dir;
                        busy  <= 1'b1;
                    end
                end
                OCCUPIED: begin
                    if (vacate || timer == '0) begin
                        state <= CLEARING;
                        timer <= CLR_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                CLEARING: begin
                    if (timer == '0) begin
                        state <= FREE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= FREE;
                    timer <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/runway_occupancy_tracker.sv
// Receives grant strobes from runway_picker, tracks occupancy of runways A/B,
// flags unhonourable grants and counts accepted movements.
module runway_occupancy_tracker
    import atc_pkg::*;
#(
    parameter int unsigned OCC_CYCLES   = 8,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] signal,
    input  logic [1:0] vacate,
    output logic       A,
    output logic       B,
    output logic [1:0] dir_a,
    output logic [1:0] dir_b,
    output logic       conflict,
    output logic [7:0] movements
);

    localparam int unsigned TW = $clog2(max2(OCC_CYCLES, CLEAR_CYCLES) + 1);

    logic       valid_word;
    logic       grant_a;
    logic       grant_b;
    logic       reject_a;
    logic       reject_b;
    logic [1:0] dir;

    assign valid_word = signal[SIG_A] ^ signal[SIG_B];
    assign grant_a    = en && valid_word && signal[SIG_A];
    assign grant_b    = en && valid_word && signal[SIG_B];
    assign dir        = signal[SIG_DIR_MSB:SIG_DIR_LSB];

    runway_slot #(
        .OCC_CYCLES   (OCC_CYCLES),
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .TW           (TW)
    ) u_slot_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .grant  (grant_a),
        .dir    (dir),
        .vacate (vacate[0]),
        .busy   (A),
        .dir_q  (dir_a),
        .reject (reject_a)
    );

    runway_slot #(
        .OCC_CYCLES   (OCC_CYCLES),
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .TW           (TW)
    ) u_slot_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .grant  (grant_b),
        .dir    (dir),
        .vacate (vacate[1]),
        .busy   (B),
        .dir_q  (dir_b),
        .reject (reject_b)
    );

    // Registered conflict pulse and saturating count of accepted grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict  <= 1'b0;
            movements <= '0;
        end else begin
            conflict <= (en && !valid_word) || reject_a || reject_b;
            if (((grant_a && !reject_a) || (grant_b && !reject_b)) && movements != '1)
                movements <= movements + 1'b1;
        end
    end

endmodule
